// File: rtl/alu_acc_sequencer_if.sv
// Command handshake bundle for alu_acc_sequencer: one command per valid/ready handshake.
interface alu_acc_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_load;
  logic [WIDTH-1:0] cmd_operand;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_load,
    output cmd_operand,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_load,
    input  cmd_operand,
    output cmd_ready
  );
endinterface

// File: rtl/alu_acc_sequencer.sv
// Accumulator sequencer around an external 8-bit combinational ALU.
// Optional overflow flag output enabled by defining ALU_ACC_OVF_FLAG_EN.
module alu_acc_sequencer #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  alu_acc_sequencer_if.slave cmd,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_r,
  output logic [WIDTH-1:0] acc,
  output logic             zero,
  output logic             res_valid,
`ifdef ALU_ACC_OVF_FLAG_EN
  output logic             ovf,
`endif
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
`ifdef ALU_ACC_OVF_FLAG_EN
  logic             ovf_q, ovf_d;
  logic             ovf_calc;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      zero_q  <= 1'b1;
      b_q     <= '0;
      sel_q   <= 2'b00;
      cnt_q   <= '0;
      count_q <= '0;
`ifdef ALU_ACC_OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      zero_q  <= zero_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
`ifdef ALU_ACC_OVF_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

`ifdef ALU_ACC_OVF_FLAG_EN
  // Signed overflow from operand/result MSBs; only add and sub can overflow.
  always_comb begin
    ovf_calc = 1'b0;
    unique case (sel_q)
      2'b00:   ovf_calc = (acc_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_r[WIDTH-1] != acc_q[WIDTH-1]);
      2'b01:   ovf_calc = (acc_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_r[WIDTH-1] != acc_q[WIDTH-1]);
      default: ovf_calc = 1'b0;
    endcase
  end
`endif

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    zero_d  = zero_q;
    b_d     = b_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    count_d = count_q;
`ifdef ALU_ACC_OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cmd.cmd_valid) begin
          if (cmd.cmd_load) begin
            acc_d   = cmd.cmd_operand;
            zero_d  = (cmd.cmd_operand == '0);
`ifdef ALU_ACC_OVF_FLAG_EN
            ovf_d   = 1'b0;
`endif
            state_d = StDone;
          end else begin
            b_d     = cmd.cmd_operand;
            sel_d   = cmd.cmd_op;
            cnt_d   = 4'(SETTLE - 1);
            state_d = StExec;
          end
        end
      end
      StExec: begin
        if (cnt_q == '0) begin
          acc_d   = alu_r;
          zero_d  = (alu_r == '0);
`ifdef ALU_ACC_OVF_FLAG_EN
          ovf_d   = ovf_calc;
`endif
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone: begin
        count_d = count_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign cmd.cmd_ready = (state_q == StIdle);
  assign res_valid     = (state_q == StDone);
  assign alu_a         = acc_q;
  assign alu_b         = b_q;
  assign alu_sel       = sel_q;
  assign acc           = acc_q;
  assign zero          = zero_q;
  assign op_count      = count_q;
`ifdef ALU_ACC_OVF_FLAG_EN
  assign ovf           = ovf_q;
`endif

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Directed self-checking bench for alu_acc_sequencer with a behavioural ALU attached.
module tb_alu_acc_sequencer;

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] alu_a, alu_b, alu_r, acc;
  logic [1:0]       alu_sel;
  logic             zero, res_valid;
  logic [CNT_W-1:0] op_count;
`ifdef ALU_ACC_OVF_FLAG_EN
  logic             ovf;
`endif

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  alu_acc_sequencer_if #(.WIDTH(WIDTH)) cmd_bus ();

  alu_acc_sequencer #(
    .WIDTH (WIDTH),
    .SETTLE(SETTLE),
    .CNT_W (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd      (cmd_bus.slave),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_r    (alu_r),
    .acc      (acc),
    .zero     (zero),
    .res_valid(res_valid),
`ifdef ALU_ACC_OVF_FLAG_EN
    .ovf      (ovf),
`endif
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  // External combinational ALU
  always_comb begin
    unique case (alu_sel)
      2'b00:   alu_r = alu_a + alu_b;
      2'b01:   alu_r = alu_a - alu_b;
      2'b10:   alu_r = alu_a ^ alu_b;
      default: alu_r = {alu_a[WIDTH-2:0], 1'b0};
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command from IDLE (called at posedge+1), run it to completion.
  task automatic do_cmd(input logic load, input logic [1:0] op, input logic [7:0] operand,
                        input logic [7:0] exp_acc, input int exp_lat);
    int lat;
    check("ready_idle", 32'(cmd_bus.cmd_ready), 32'd1);
    cmd_bus.cmd_valid   = 1'b1;
    cmd_bus.cmd_load    = load;
    cmd_bus.cmd_op      = op;
    cmd_bus.cmd_operand = operand;
    tick();
    cmd_bus.cmd_valid = 1'b0;
    lat = 1;
    while (!res_valid && lat < 40) begin
      check("ready_busy", 32'(cmd_bus.cmd_ready), 32'd0);
      if (!load) begin
        check("alu_b_held", 32'(alu_b), 32'(operand));
        check("alu_sel_held", 32'(alu_sel), 32'(op));
      end
      tick();
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("acc", 32'(acc), 32'(exp_acc));
    check("zero", 32'(zero), 32'(exp_acc == 8'h00));
    tick();
    exp_cnt = (exp_cnt + 1) % 256;
    check("res_valid_pulse", 32'(res_valid), 32'd0);
    check("op_count", 32'(op_count), 32'(exp_cnt));
  endtask

  initial begin
    logic saw_valid;
    cmd_bus.cmd_valid   = 1'b0;
    cmd_bus.cmd_load    = 1'b0;
    cmd_bus.cmd_op      = 2'b00;
    cmd_bus.cmd_operand = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_acc", 32'(acc), 32'h0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'h0);
    check("rst_alu_sel", 32'(alu_sel), 32'h0);

    do_cmd(1'b1, 2'b00, 8'h05, 8'h05, 1);
    do_cmd(1'b0, 2'b00, 8'h03, 8'h08, SETTLE + 1);
    do_cmd(1'b0, 2'b01, 8'h08, 8'h00, SETTLE + 1);
    do_cmd(1'b0, 2'b11, 8'h5A, 8'h00, SETTLE + 1);
    do_cmd(1'b1, 2'b00, 8'h81, 8'h81, 1);
    do_cmd(1'b0, 2'b11, 8'hFF, 8'h02, SETTLE + 1);
    do_cmd(1'b1, 2'b00, 8'h55, 8'h55, 1);
    do_cmd(1'b0, 2'b10, 8'hFF, 8'hAA, SETTLE + 1);
`ifdef ALU_ACC_OVF_FLAG_EN
    do_cmd(1'b1, 2'b00, 8'h7F, 8'h7F, 1);
    check("ovf_load", 32'(ovf), 32'd0);
    do_cmd(1'b0, 2'b00, 8'h01, 8'h80, SETTLE + 1);
    check("ovf_add", 32'(ovf), 32'd1);
    do_cmd(1'b0, 2'b01, 8'h01, 8'h7F, SETTLE + 1);
    check("ovf_sub", 32'(ovf), 32'd1);
    do_cmd(1'b0, 2'b10, 8'h01, 8'h7E, SETTLE + 1);
    check("ovf_xor", 32'(ovf), 32'd0);
    do_cmd(1'b1, 2'b00, 8'hAA, 8'hAA, 1);
`endif

    // Valid held high with changing operands while busy: only the first command runs.
    cmd_bus.cmd_valid   = 1'b1;
    cmd_bus.cmd_load    = 1'b0;
    cmd_bus.cmd_op      = 2'b00;
    cmd_bus.cmd_operand = 8'h01;
    tick();
    for (int i = 1; i <= 3; i++) begin
      check("busy_ready", 32'(cmd_bus.cmd_ready), 32'd0);
      cmd_bus.cmd_operand = 8'(16 * i);
      cmd_bus.cmd_load    = i[0];
      cmd_bus.cmd_op      = 2'(i);
      if (i < 3) tick();
    end
    check("busy_res_valid", 32'(res_valid), 32'd1);
    check("busy_acc", 32'(acc), 32'hAB);
    tick();
    cmd_bus.cmd_valid = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    check("busy_back_idle", 32'(cmd_bus.cmd_ready), 32'd1);
    check("busy_op_count", 32'(op_count), 32'(exp_cnt));
    tick();
    check("busy_no_second", 32'(acc), 32'hAB);
    check("busy_no_second_cnt", 32'(op_count), 32'(exp_cnt));

    // Reset in the middle of EXEC discards the command.
    cmd_bus.cmd_valid   = 1'b1;
    cmd_bus.cmd_load    = 1'b0;
    cmd_bus.cmd_op      = 2'b00;
    cmd_bus.cmd_operand = 8'h11;
    tick();
    cmd_bus.cmd_valid = 1'b0;
    check("mid_exec_busy", 32'(cmd_bus.cmd_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    check("mid_rst_ready", 32'(cmd_bus.cmd_ready), 32'd1);
    check("mid_rst_acc", 32'(acc), 32'h0);
    check("mid_rst_zero", 32'(zero), 32'd1);
    check("mid_rst_op_count", 32'(op_count), 32'd0);
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (res_valid) saw_valid = 1'b1;
      tick();
    end
    check("mid_rst_no_pulse", 32'(saw_valid), 32'd0);

    // 256 loads wrap the 8-bit op counter.
    for (int i = 0; i < 256; i++) begin
      cmd_bus.cmd_valid   = 1'b1;
      cmd_bus.cmd_load    = 1'b1;
      cmd_bus.cmd_operand = 8'(i);
      tick();
      cmd_bus.cmd_valid = 1'b0;
      tick();
      if (i == 254) check("cnt_255", 32'(op_count), 32'd255);
    end
    check("cnt_wrap", 32'(op_count), 32'd0);
    check("wrap_acc", 32'(acc), 32'hFF);
    check("wrap_zero", 32'(zero), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/alu_acc_sequencer.md
Name: alu_acc_sequencer

Overview:
- Control stage wrapped around the 8-bit combinational ALU (sel: 00 add, 01 sub, 10 xor, 11 shift-left-by-1 of A).
- Accepts one command at a time through a valid/ready handshake and drives the ALU's A, B and sel from registers.
- Holds ALU inputs stable for a programmable settle time, then captures R into an 8-bit accumulator and reports completion.
- Accumulator is always ALU operand A; the command operand is ALU operand B.

Parameters:
- WIDTH, 8, datapath width; must match the ALU, which is fixed at 8.
- SETTLE, 2, number of EXEC cycles the ALU inputs are held before R is captured; legal range 1–15.
- CNT_W, 8, width of the completed-operation counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  ALU select for this command.
- cmd_load  in  1  1 = load cmd_operand into the accumulator with no ALU operation; cmd_op is ignored.
- cmd_operand  in  WIDTH  B operand, or the load value.
- alu_a  out  WIDTH  to ALU A; equals the accumulator.
- alu_b  out  WIDTH  to ALU B; registered operand.
- alu_sel  out  2  to ALU sel; registered op.
- alu_r  in  WIDTH  from ALU R.
- acc  out  WIDTH  accumulator value.
- zero  out  1  acc == 0, registered together with acc.
- res_valid  out  1  one-cycle completion pulse.
- op_count  out  CNT_W  number of completed commands; wraps modulo 2^CNT_W.

Behaviour:
- Reset, when rst is high at a clock edge, takes priority over everything, including mid-EXEC. Resulting values:
  - state = IDLE; acc = 0; zero = 1.
  - alu_b = 0; alu_sel = 00; res_valid = 0; op_count = 0; settle counter = 0.
  - A command in flight is discarded and is not counted.
- States: IDLE, EXEC, DONE.
- IDLE:
  - cmd_ready = 1.
  - Handshake fires on cmd_valid & cmd_ready at a rising edge.
  - If cmd_load = 1: acc <= cmd_operand, zero updated, next state DONE.
  - Otherwise: alu_b <= cmd_operand, alu_sel <= cmd_op, settle counter <= SETTLE-1, next state EXEC.
  - cmd_valid low: stay in IDLE with all registers held.
- EXEC:
  - cmd_ready = 0; alu_a, alu_b and alu_sel are held constant.
  - Counter decrements each cycle.
  - On the edge where the counter is 0: acc <= alu_r, zero <= (alu_r == 0), next state DONE.
  - EXEC therefore lasts exactly SETTLE cycles.
- DONE:
  - res_valid = 1 for exactly this one cycle; cmd_ready = 0.
  - op_count increments on the edge leaving DONE; next state IDLE.
  - From 2^CNT_W−1, op_count wraps to 0 with no flag.
- Latency, measured from the handshake edge to the first cycle res_valid is high:
  - ALU op: SETTLE+1 cycles.
  - Load: 1 cycle.
- Throughput:
  - One ALU op per SETTLE+2 cycles.
  - One load per 2 cycles.
- cmd_valid, cmd_op, cmd_load and cmd_operand are ignored whenever cmd_ready = 0; there is no buffering.
- alu_a is combinationally tied to acc, so back-to-back ops chain results: acc = acc op B.
- Shift op: alu_b is still loaded but has no effect on R; acc <= {acc[6:0],0}.
- Arithmetic is modulo 2^8; the carry out of the ALU is not observed.

Optional Feature:
- Macro: ALU_ACC_OVF_FLAG_EN.
- When defined, adds an output port ovf (1 bit, reset 0), updated on the same edge as acc:
  - add: ovf <= (a7 == b7) & (r7 != a7).
  - sub: ovf <= (a7 != b7) & (r7 != a7).
  - xor and shift: ovf <= 0.
  - load: ovf <= 0.
  - Here a7, b7 and r7 are the MSBs of alu_a, alu_b and alu_r.
- When not defined: no ovf port, no associated logic, and all other behaviour is identical.

Test Plan:
- Reset, then load 0x05 → res_valid one cycle after the handshake; acc = 0x05, zero = 0, op_count = 1.
- acc = 0x05, SETTLE = 2, op add with operand 0x03 → alu_sel = 00 and alu_b = 0x03 held 2 cycles; res_valid at handshake+3; acc = 0x08.
- acc = 0x08, sub with 0x08 → acc = 0x00, zero = 1. Then shift → acc = 0x00. Then load 0x81, shift → acc = 0x02.
- acc = 0x55, xor with 0xFF → acc = 0xAA.
  - With ALU_ACC_OVF_FLAG_EN: load 0x7F, add 0x01 → acc = 0x80, ovf = 1. Then sub 0x01 → acc = 0x7F, ovf = 1.
- Hold cmd_valid high with changing operands during EXEC/DONE → only the first command is executed; cmd_ready = 0 until IDLE.
- Assert rst in the middle of EXEC → next cycle state IDLE, acc = 0, op_count = 0, res_valid never pulses. Issue 256 loads with CNT_W = 8 → op_count wraps to 0.
